// File: rtl/fpu_issue_wb.sv
// fpu_issue_wb: issue/writeback controller for the FPU cluster.
// One tagged op per cycle is accepted and started on its one-hot unit. A
// reservation shift register (depth MAX_LAT) records which unit's result is
// due in which cycle. An op is refused when its due slot is already taken
// on the single writeback port.
//
// Ports:
//   sys_clk, rst              clock, synchronous active-high reset
//   in_valid/in_op/in_tag     issue request (in_op one-hot unit select)
//   in_ready                  combinational issue acceptance
//   unit_start                one-hot start strobe (in_op when accepted)
//   unit_y/valid/ovf/unf      per-unit result, valid and flags
//   out_valid/data/tag/ovf/unf registered writeback of the due result
//   out_err                   due unit failed to raise unit_valid
//   stray_err                 sticky: unit_valid with nothing due for it
//   busy                      any reservation outstanding
module fpu_issue_wb #(
    parameter int NUM_UNITS = 8,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 5,
    parameter int LAT_W     = 3,
    parameter int MAX_LAT   = 7,
    parameter logic [NUM_UNITS*LAT_W-1:0] UNIT_LAT =
        {3'd1, 3'd2, 3'd1, 3'd3, 3'd6, 3'd3, 3'd3, 3'd3}
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [NUM_UNITS-1:0]        in_op,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        in_ready,
    output logic [NUM_UNITS-1:0]        unit_start,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_y,
    input  logic [NUM_UNITS-1:0]        unit_valid,
    input  logic [NUM_UNITS-1:0]        unit_ovf,
    input  logic [NUM_UNITS-1:0]        unit_unf,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [TAG_W-1:0]            out_tag,
    output logic                        out_ovf,
    output logic                        out_unf,
    output logic                        out_err,
    output logic                        stray_err,
    output logic                        busy
);
    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [NUM_UNITS-1:0] UNIT_ONE = 1;

    typedef struct packed {
        logic             v;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t [MAX_LAT-1:0]                res_q, res_d;
    // Unit masks of ops discarded by reset, kept on their original schedule so
    // their late results are recognised and not reported as stray.
    logic [MAX_LAT-1:0][NUM_UNITS-1:0] ghost_q, ghost_d;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic                 out_ovf_q, out_ovf_d;
    logic                 out_unf_q, out_unf_d;
    logic                 out_err_q, out_err_d;
    logic                 stray_err_q, stray_err_d;

    logic [IDX_W-1:0]     op_idx;
    logic [LAT_W-1:0]     op_lat;
    logic                 slot_free;
    logic                 accept;
    res_t                 due;
    logic [NUM_UNITS-1:0] due_mask;

    // Issue decode and legality
    always_comb begin
        op_idx = '0;
        for (int i = 0; i < NUM_UNITS; i++)
            if (in_op[i]) op_idx = IDX_W'(i);
        op_lat = UNIT_LAT[op_idx*LAT_W +: LAT_W];
        // Entry res[L] would shift into res[L-1] at this edge; L==MAX_LAT
        // never matches and so is always free.
        slot_free = 1'b1;
        for (int k = 1; k < MAX_LAT; k++)
            if (op_lat == LAT_W'(k) && res_q[k].v) slot_free = 1'b0;
        in_ready   = !rst && $onehot(in_op) && slot_free;
        accept     = in_valid && in_ready;
        unit_start = accept ? in_op : '0;
    end

    // Reservation shift plus insertion of the accepted op
    always_comb begin
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            res_d[k]   = res_q[k+1];
            ghost_d[k] = ghost_q[k+1];
            if (rst && res_q[k+1].v) ghost_d[k] = ghost_d[k] | (UNIT_ONE << res_q[k+1].idx);
        end
        res_d[MAX_LAT-1]   = '0;
        ghost_d[MAX_LAT-1] = '0;
        for (int k = 0; k < MAX_LAT; k++)
            if (accept && op_lat == LAT_W'(k + 1))
                res_d[k] = '{v: 1'b1, idx: op_idx, tag: in_tag};
    end

    // Writeback capture and result-schedule checks
    always_comb begin
        due         = res_q[0];
        due_mask    = due.v ? (UNIT_ONE << due.idx) : '0;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;
        if (due.v) begin
            out_valid_d = 1'b1;
            out_data_d  = unit_y[due.idx*DATA_W +: DATA_W];
            out_tag_d   = due.tag;
            out_ovf_d   = unit_ovf[due.idx];
            out_unf_d   = unit_unf[due.idx];
            out_err_d   = !unit_valid[due.idx];
        end
        stray_err_d = stray_err_q | (|(unit_valid & ~due_mask & ~ghost_q[0]));
    end

    always_ff @(posedge sys_clk) begin
        ghost_q <= ghost_d;
        if (rst) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
            out_err_q   <= 1'b0;
            stray_err_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
            out_err_q   <= out_err_d;
            stray_err_q <= stray_err_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < MAX_LAT; k++) busy = busy | res_q[k].v;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;
    assign out_err   = out_err_q;
    assign stray_err = stray_err_q;
endmodule

// File: tb/tb_fpu_issue_wb.sv
// Testbench for fpu_issue_wb: directed scenarios plus a randomized run
// against a schedule-based model (ops recorded by absolute due cycle).
module tb_fpu_issue_wb;
    logic         sys_clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [7:0]   in_op;
    logic [4:0]   in_tag;
    logic         in_ready;
    logic [7:0]   unit_start;
    logic [255:0] unit_y;
    logic [7:0]   unit_valid, unit_ovf, unit_unf;
    logic         out_valid, out_ovf, out_unf, out_err, stray_err, busy;
    logic [31:0]  out_data;
    logic [4:0]   out_tag;

    fpu_issue_wb dut (
        .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_tag(in_tag),
        .in_ready(in_ready), .unit_start(unit_start), .unit_y(unit_y), .unit_valid(unit_valid),
        .unit_ovf(unit_ovf), .unit_unf(unit_unf), .out_valid(out_valid), .out_data(out_data),
        .out_tag(out_tag), .out_ovf(out_ovf), .out_unf(out_unf), .out_err(out_err),
        .stray_err(stray_err), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Unit latencies: fadd..fabs as listed in the unit table (unit 0 first).
    int lat[8] = '{3, 3, 3, 6, 3, 1, 2, 1};

    int errs = 0, checks = 0, cyc = 0, npend = 0;
    bit         pend_v[256];
    int         pend_unit[256];
    logic [4:0] pend_tag[256];
    logic [7:0] ghost[256];

    logic        y_fix_en = 1'b0;
    logic [31:0] y_fix;
    logic [7:0]  stray_inj = 8'h00;
    logic [31:0] y_arr[8];

    // Observed and model-expected values for the last cycle driven
    logic        obs_ready, obs_busy, obs_ov, obs_ovf, obs_unf, obs_err, obs_stray;
    logic [7:0]  obs_start;
    logic [31:0] obs_data;
    logic [4:0]  obs_tag;
    logic        exp_ready, exp_busy, exp_ov, exp_ovf, exp_unf, exp_err, exp_stray;
    logic [7:0]  exp_start;
    logic [31:0] exp_data;
    logic [4:0]  exp_tag;

    // Drives one cycle, samples combinational outputs mid-cycle, advances the
    // model, then samples the registered outputs #1 after the edge.
    task automatic drive_cycle(input logic v, input logic [7:0] op, input logic [4:0] tag,
                               input bit drop);
        int slot, u, L, s;
        logic [7:0] due_mask, uv;
        slot = cyc % 256;
        in_valid = v; in_op = op; in_tag = tag;
        for (int i = 0; i < 8; i++) begin
            y_arr[i] = y_fix_en ? y_fix : $urandom;
            unit_y[i*32 +: 32] = y_arr[i];
        end
        unit_ovf = 8'($urandom); unit_unf = 8'($urandom);
        due_mask = pend_v[slot] ? (8'h01 << pend_unit[slot]) : 8'h00;
        uv = (drop ? 8'h00 : due_mask) | ghost[slot] | stray_inj;
        unit_valid = uv;
        #2;
        obs_ready = in_ready; obs_start = unit_start; obs_busy = busy;
        u = 0;
        for (int i = 0; i < 8; i++) if (op[i]) u = i;
        L = lat[u];
        exp_busy  = (npend != 0);
        exp_ready = !rst && ($countones(op) == 1) && !pend_v[(cyc + L) % 256];
        exp_start = (v && exp_ready) ? op : 8'h00;
        if (rst) begin
            for (int k = 1; k < 8; k++) begin
                s = (cyc + k) % 256;
                if (pend_v[s]) ghost[s] |= 8'h01 << pend_unit[s];
                pend_v[s] = 1'b0;
            end
            pend_v[slot] = 1'b0; ghost[slot] = 8'h00; npend = 0;
            exp_ov = 0; exp_data = 0; exp_tag = 0; exp_ovf = 0; exp_unf = 0;
            exp_err = 0; exp_stray = 0;
        end else begin
            if (pend_v[slot]) begin
                exp_ov = 1; exp_data = y_arr[pend_unit[slot]]; exp_tag = pend_tag[slot];
                exp_ovf = unit_ovf[pend_unit[slot]]; exp_unf = unit_unf[pend_unit[slot]];
                exp_err = !uv[pend_unit[slot]];
                pend_v[slot] = 1'b0; npend--;
            end else begin
                exp_ov = 0; exp_err = 0;
            end
            if ((uv & ~due_mask & ~ghost[slot]) != 8'h00) exp_stray = 1;
            ghost[slot] = 8'h00;
            if (v && exp_ready) begin
                s = (cyc + L) % 256;
                pend_v[s] = 1'b1; pend_unit[s] = u; pend_tag[s] = tag; npend++;
            end
        end
        @(posedge sys_clk); #1;
        cyc++;
        obs_ov = out_valid; obs_data = out_data; obs_tag = out_tag; obs_ovf = out_ovf;
        obs_unf = out_unf; obs_err = out_err; obs_stray = stray_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 8'h01, 5'd3, 1'b0);
        checks++; if (obs_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got=%b want=0", obs_ready); end
        checks++; if (obs_start !== 8'h00) begin errs++; $display("FAIL reset_start got=%h want=00", obs_start); end
        checks++; if ({obs_ov, obs_data, obs_tag, obs_ovf, obs_unf, obs_err, obs_stray} !== '0)
            begin errs++; $display("FAIL reset_outs got v=%b d=%h t=%h o=%b u=%b e=%b s=%b want all 0",
                obs_ov, obs_data, obs_tag, obs_ovf, obs_unf, obs_err, obs_stray); end
        rst = 1'b0;
        drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
        checks++; if (obs_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", obs_busy); end
    endtask

    task automatic test_single_fadd();
        y_fix_en = 1'b1; y_fix = 32'h40400000;
        drive_cycle(1'b1, 8'h01, 5'd5, 1'b0);
        checks++; if (obs_start !== 8'h01) begin errs++; $display("FAIL fadd_start got=%h want=01", obs_start); end
        checks++; if (obs_ov !== 1'b0) begin errs++; $display("FAIL fadd_early got=%b want=0", obs_ov); end
        for (int i = 1; i <= 3; i++) begin
            drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
            checks++; if (obs_ov !== (i == 3)) begin errs++; $display("FAIL fadd_valid i=%0d got=%b want=%b", i, obs_ov, i == 3); end
        end
        checks++; if (obs_data !== 32'h40400000 || obs_tag !== 5'd5 || obs_err !== 1'b0)
            begin errs++; $display("FAIL fadd_wb got d=%h t=%0d e=%b want d=40400000 t=5 e=0", obs_data, obs_tag, obs_err); end
        y_fix_en = 1'b0;
    endtask

    task automatic test_out_of_order();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) drive_cycle(1'b1, 8'h08, 5'd1, 1'b0);
            else if (i == 1) drive_cycle(1'b1, 8'h20, 5'd2, 1'b0);
            else drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
            checks++; if (obs_busy !== (i >= 1 && i <= 6)) begin errs++; $display("FAIL ooo_busy i=%0d got=%b", i, obs_busy); end
            checks++; if (obs_ov !== (i == 2 || i == 6)) begin errs++; $display("FAIL ooo_valid i=%0d got=%b", i, obs_ov); end
            if (i == 2) begin checks++; if (obs_tag !== 5'd2) begin errs++; $display("FAIL ooo_tag_ftoi got=%0d want=2", obs_tag); end end
            if (i == 6) begin checks++; if (obs_tag !== 5'd1) begin errs++; $display("FAIL ooo_tag_fdiv got=%0d want=1", obs_tag); end end
        end
    endtask

    task automatic test_collision();
        drive_cycle(1'b1, 8'h01, 5'd3, 1'b0);
        checks++; if (obs_ready !== 1'b1) begin errs++; $display("FAIL coll_first got=%b want=1", obs_ready); end
        drive_cycle(1'b1, 8'h40, 5'd4, 1'b0);
        checks++; if (obs_ready !== 1'b0 || obs_start !== 8'h00)
            begin errs++; $display("FAIL coll_block got r=%b s=%h want r=0 s=00", obs_ready, obs_start); end
        drive_cycle(1'b1, 8'h40, 5'd4, 1'b0);
        checks++; if (obs_ready !== 1'b1 || obs_start !== 8'h40)
            begin errs++; $display("FAIL coll_retry got r=%b s=%h want r=1 s=40", obs_ready, obs_start); end
        for (int i = 3; i <= 6; i++) begin
            drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
            if (i == 3 || i == 4) begin
                checks++; if (obs_ov !== 1'b1 || obs_tag !== 5'(i))
                    begin errs++; $display("FAIL coll_wb i=%0d got v=%b t=%0d want v=1 t=%0d", i, obs_ov, obs_tag, i); end
            end
        end
    endtask

    task automatic test_bad_op();
        drive_cycle(1'b1, 8'b00000101, 5'd7, 1'b0);
        checks++; if (obs_ready !== 1'b0 || obs_start !== 8'h00)
            begin errs++; $display("FAIL bad_multi got r=%b s=%h want r=0 s=00", obs_ready, obs_start); end
        drive_cycle(1'b1, 8'h00, 5'd7, 1'b0);
        checks++; if (obs_ready !== 1'b0 || obs_start !== 8'h00)
            begin errs++; $display("FAIL bad_zero got r=%b s=%h want r=0 s=00", obs_ready, obs_start); end
        drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
        checks++; if (obs_busy !== 1'b0) begin errs++; $display("FAIL bad_busy got=%b want=0", obs_busy); end
    endtask

    task automatic test_random();
        logic [7:0] op;
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
            if (n >= 290) drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
            else drive_cycle(1'($urandom_range(0, 3) != 0), op, 5'($urandom), 1'b0);
            checks++; if (obs_ready !== exp_ready || obs_start !== exp_start || obs_busy !== exp_busy)
                begin errs++; $display("FAIL rnd_issue n=%0d got r=%b s=%h b=%b want r=%b s=%h b=%b",
                    n, obs_ready, obs_start, obs_busy, exp_ready, exp_start, exp_busy); end
            checks++; if (obs_ov !== exp_ov || obs_err !== exp_err || obs_stray !== exp_stray)
                begin errs++; $display("FAIL rnd_valid n=%0d got v=%b e=%b s=%b want v=%b e=%b s=%b",
                    n, obs_ov, obs_err, obs_stray, exp_ov, exp_err, exp_stray); end
            if (exp_ov) begin
                checks++; if (obs_data !== exp_data || obs_tag !== exp_tag || obs_ovf !== exp_ovf || obs_unf !== exp_unf)
                    begin errs++; $display("FAIL rnd_wb n=%0d got d=%h t=%0d o=%b u=%b want d=%h t=%0d o=%b u=%b",
                        n, obs_data, obs_tag, obs_ovf, obs_unf, exp_data, exp_tag, exp_ovf, exp_unf); end
            end
        end
    endtask

    task automatic test_missing_stray();
        drive_cycle(1'b1, 8'h04, 5'd9, 1'b0);
        drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
        drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
        drive_cycle(1'b0, 8'h00, 5'd0, 1'b1);
        checks++; if (obs_ov !== 1'b1 || obs_err !== 1'b1 || obs_tag !== 5'd9)
            begin errs++; $display("FAIL missing got v=%b e=%b t=%0d want v=1 e=1 t=9", obs_ov, obs_err, obs_tag); end
        checks++; if (obs_stray !== 1'b0) begin errs++; $display("FAIL missing_nostray got=%b want=0", obs_stray); end
        stray_inj = 8'h80;
        drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
        stray_inj = 8'h00;
        checks++; if (obs_stray !== 1'b1 || obs_err !== 1'b0)
            begin errs++; $display("FAIL stray_set got s=%b e=%b want s=1 e=0", obs_stray, obs_err); end
        drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
        checks++; if (obs_stray !== 1'b1) begin errs++; $display("FAIL stray_sticky got=%b want=1", obs_stray); end
    endtask

    task automatic test_reset_inflight();
        drive_cycle(1'b1, 8'h08, 5'd1, 1'b0);
        drive_cycle(1'b1, 8'h01, 5'd2, 1'b0);
        drive_cycle(1'b1, 8'h10, 5'd3, 1'b0);
        checks++; if (obs_ready !== 1'b1 || obs_busy !== 1'b1)
            begin errs++; $display("FAIL flight_issue got r=%b b=%b want r=1 b=1", obs_ready, obs_busy); end
        rst = 1'b1;
        drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
        rst = 1'b0;
        checks++; if ({obs_ov, obs_data, obs_tag, obs_ovf, obs_unf, obs_err, obs_stray} !== '0)
            begin errs++; $display("FAIL flight_rst got v=%b d=%h t=%h e=%b s=%b want all 0",
                obs_ov, obs_data, obs_tag, obs_err, obs_stray); end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 8'h00, 5'd0, 1'b0);
            checks++; if (obs_busy !== 1'b0 || obs_ov !== 1'b0 || obs_stray !== 1'b0)
                begin errs++; $display("FAIL flight_after i=%0d got b=%b v=%b s=%b want 0 0 0",
                    i, obs_busy, obs_ov, obs_stray); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_tag = '0;
        unit_y = '0; unit_valid = '0; unit_ovf = '0; unit_unf = '0;
        for (int i = 0; i < 256; i++) begin pend_v[i] = 1'b0; ghost[i] = 8'h00; end
        test_reset();
        test_single_fadd();
        test_out_of_order();
        test_collision();
        test_bad_op();
        test_random();
        test_missing_stray();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule
